// File: rtl/sha2_pkg.sv
// sha2_pkg: shared types and constants for the SHA-2 block engine.
// Holds the FSM state enum, round-constant tables for SHA-256/512,
// initial hash values and the rotation amounts for each word size.
package sha2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rotation / shift amounts for the four sigma functions.
    typedef struct packed {
        int unsigned bs0a, bs0b, bs0c;   // big sigma0: rotr x3
        int unsigned bs1a, bs1b, bs1c;   // big sigma1: rotr x3
        int unsigned ss0a, ss0b, ss0sh;  // small sigma0: rotr, rotr, shr
        int unsigned ss1a, ss1b, ss1sh;  // small sigma1: rotr, rotr, shr
    } rot_t;

    localparam rot_t ROT32 = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};
    localparam rot_t ROT64 = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};

    localparam logic [255:0] H0_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [511:0] H0_512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

    // Index 0 sits in the MSBs so element [t] is K[t].
    localparam logic [0:63][31:0] K256 = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [0:79][63:0] K512 = {
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

endpackage

// File: rtl/sha2_block_engine_if.sv
// sha2_block_engine_if: block-in / digest-out handshake bundle.
// master = block producer / digest consumer, slave = the engine.
interface sha2_block_engine_if #(parameter int WORDSIZE = 32);
    logic [8*WORDSIZE-1:0]  H_in;
    logic [16*WORDSIZE-1:0] M_in;
    logic                   input_valid;
    logic                   input_ready;
    logic [8*WORDSIZE-1:0]  H_out;
    logic                   output_valid;
    logic                   output_ready;

    modport master (
        output H_in, M_in, input_valid, output_ready,
        input  input_ready, H_out, output_valid
    );

    modport slave (
        input  H_in, M_in, input_valid, output_ready,
        output input_ready, H_out, output_valid
    );
endinterface

// File: rtl/sha2_K_rom.sv
// sha2_K_rom: combinational round-constant lookup, table chosen by WORDSIZE.
module sha2_K_rom
    import sha2_pkg::*;
#(
    parameter int WORDSIZE = 32
) (
    input  logic [$clog2((WORDSIZE == 64) ? 80 : 64)-1:0] i_idx,
    output logic [WORDSIZE-1:0]                           o_k
);

    if (WORDSIZE == 64) begin : g_k512
        assign o_k = K512[i_idx];
    end else begin : g_k256
        assign o_k = K256[i_idx];
    end

endmodule

// File: rtl/sha2_block_engine.sv
// sha2_block_engine: one SHA-2 compression per accepted block, one round
// per clock. WORDSIZE=32 -> SHA-256 (64 rounds), 64 -> SHA-512 (80 rounds).
// Build option SHA2_H_LATCH_EN: capture H_in at accept so the producer may
// change it afterwards; otherwise the feed-forward uses live H_in.
module sha2_block_engine
    import sha2_pkg::*;
#(
    parameter int WORDSIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha2_block_engine_if.slave   bus
);

    if (WORDSIZE != 32 && WORDSIZE != 64) begin : g_bad_ws
        $error("sha2_block_engine: WORDSIZE must be 32 or 64");
    end

    localparam int   R   = (WORDSIZE == 64) ? 80 : 64;
    localparam int   CW  = $clog2(R);
    localparam rot_t ROT = (WORDSIZE == 64) ? ROT64 : ROT32;

    typedef logic [WORDSIZE-1:0] word_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORDSIZE - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, ROT.bs0a) ^ rotr(x, ROT.bs0b) ^ rotr(x, ROT.bs0c);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, ROT.bs1a) ^ rotr(x, ROT.bs1b) ^ rotr(x, ROT.bs1c);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, ROT.ss0a) ^ rotr(x, ROT.ss0b) ^ (x >> ROT.ss0sh);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, ROT.ss1a) ^ rotr(x, ROT.ss1b) ^ (x >> ROT.ss1sh);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t                    r_state, w_next;
    logic [CW-1:0]             r_cnt;
    logic                      r_fold;      // all rounds done, feed-forward next edge
    logic [0:7][WORDSIZE-1:0]  r_v;         // working registers a..h
    logic [0:15][WORDSIZE-1:0] r_w;         // schedule window, [0] = W[t]
    logic [0:7][WORDSIZE-1:0]  r_hout;
    logic [0:7][WORDSIZE-1:0]  w_hin;
    logic [0:7][WORDSIZE-1:0]  w_hsrc;
    logic [0:7][WORDSIZE-1:0]  w_sum;
    word_t                     w_k, w_t1, w_t2, w_wnew;
    logic                      w_accept;
    logic                      w_in_rdy, w_out_vld;

    assign w_hin    = bus.H_in;
    assign w_accept = (r_state == IDLE) && bus.input_valid;

`ifdef SHA2_H_LATCH_EN
    logic [0:7][WORDSIZE-1:0] r_hin;
    assign w_hsrc = r_hin;
`else
    assign w_hsrc = w_hin;
`endif

    sha2_K_rom #(.WORDSIZE(WORDSIZE)) u_krom (
        .i_idx (r_cnt),
        .o_k   (w_k)
    );

    // Round function, next schedule word and final feed-forward sums.
    always_comb begin
        w_t1   = r_v[7] + bsig1(r_v[4]) + ch(r_v[4], r_v[5], r_v[6]) + w_k + r_w[0];
        w_t2   = bsig0(r_v[0]) + maj(r_v[0], r_v[1], r_v[2]);
        w_wnew = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
        w_sum  = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = w_hsrc[i] + r_v[i];
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        w_in_rdy  = 1'b0;
        w_out_vld = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_rdy = 1'b1;
                if (bus.input_valid) w_next = ROUND;
            end
            ROUND: begin
                if (r_fold) w_next = DONE;
            end
            DONE: begin
                w_out_vld = 1'b1;
                if (bus.output_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.input_ready  = w_in_rdy;
    assign bus.output_valid = w_out_vld;
    assign bus.H_out        = r_hout;

    // State, round counter and fold flag; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_fold  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt  <= '0;
                r_fold <= 1'b0;
            end else if (r_state == ROUND && !r_fold) begin
                // Counter parks on R-1 rather than wrapping.
                if (r_cnt == CW'(R - 1)) r_fold <= 1'b1;
                else                     r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // Datapath: load on accept, one round per ROUND cycle, then feed-forward.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_v <= w_hin;
            r_w <= bus.M_in;
`ifdef SHA2_H_LATCH_EN
            r_hin <= w_hin;
`endif
        end else if (r_state == ROUND && !r_fold) begin
            r_v <= {w_t1 + w_t2, r_v[0], r_v[1], r_v[2],
                    r_v[3] + w_t1, r_v[4], r_v[5], r_v[6]};
            for (int i = 0; i < 15; i++) begin
                r_w[i] <= r_w[i+1];
            end
            r_w[15] <= w_wnew;
        end else if (r_state == ROUND && r_fold) begin
            r_hout <= w_sum;
        end
    end

endmodule

// File: tb/tb_sha2_block_engine.sv
// tb_sha2_block_engine: directed vectors for SHA-256 and SHA-512 instances.
module tb_sha2_block_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha2_block_engine_if #(.WORDSIZE(32)) bus32();
    sha2_block_engine_if #(.WORDSIZE(64)) bus64();

    sha2_block_engine #(.WORDSIZE(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    sha2_block_engine #(.WORDSIZE(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    localparam logic [255:0] H256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] H512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0]  M_ABC32 = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [1023:0] M_ABC64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
    localparam logic [255:0]  D_ABC32 = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] M_Q1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_Q2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] D_Q = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Present one block and let the engine take it on the next rising edge.
    task automatic start(input bit w64, input logic [511:0] h, input logic [1023:0] m);
        @(negedge clk);
        if (w64) begin
            chk("rdy_pre64", bus64.input_ready, 1);
            bus64.H_in = h; bus64.M_in = m; bus64.input_valid = 1'b1;
        end else begin
            chk("rdy_pre32", bus32.input_ready, 1);
            bus32.H_in = h[255:0]; bus32.M_in = m[511:0]; bus32.input_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus32.input_valid = 1'b0;
        bus64.input_valid = 1'b0;
`ifdef SHA2_H_LATCH_EN
        if (w64) for (int i = 0; i < 16; i++) bus64.H_in[i*32 +: 32] = $urandom;
        else     for (int i = 0; i < 8; i++)  bus32.H_in[i*32 +: 32] = $urandom;
`endif
    endtask

    // Count edges from the accepting edge until output_valid, bounded.
    task automatic wait_done(input bit w64, output int lat);
        logic ov;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            ov = w64 ? bus64.output_valid : bus32.output_valid;
        end while (!ov && lat < 300);
    endtask

    task automatic ack(input bit w64);
        @(negedge clk);
        if (w64) bus64.output_ready = 1'b1; else bus32.output_ready = 1'b1;
        @(posedge clk);
        #1;
        bus32.output_ready = 1'b0;
        bus64.output_ready = 1'b0;
        if (w64) begin
            chk("ov_after_ack64", bus64.output_valid, 0);
            chk("ir_after_ack64", bus64.input_ready, 1);
        end else begin
            chk("ov_after_ack32", bus32.output_valid, 0);
            chk("ir_after_ack32", bus32.input_ready, 1);
        end
    endtask

    initial begin
        int lat;
        logic [255:0] dig1;

        bus32.H_in = '0; bus32.M_in = '0; bus32.input_valid = 1'b0; bus32.output_ready = 1'b0;
        bus64.H_in = '0; bus64.M_in = '0; bus64.input_valid = 1'b0; bus64.output_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir32", bus32.input_ready, 1);
        chk("rst_ov32", bus32.output_valid, 0);
        chk("rst_ir64", bus64.input_ready, 1);
        chk("rst_ov64", bus64.output_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // SHA-256 "abc"
        start(0, H256, M_ABC32);
        wait_done(0, lat);
        chk("lat_abc32", lat, 65);
        chk("dig_abc32", bus32.H_out, D_ABC32);
        ack(0);

        // SHA-512 "abc"
        start(1, H512, M_ABC64);
        wait_done(1, lat);
        chk("lat_abc64", lat, 81);
        chk("dig_abc64_hi", bus64.H_out[511:448], 64'hddaf35a193617aba);
        chk("dig_abc64_lo", bus64.H_out[31:0], 32'ha54ca49f);
        ack(1);

        // Two-block SHA-256, chained through H_out
        start(0, H256, M_Q1);
        wait_done(0, lat);
        chk("lat_q1", lat, 65);
        dig1 = bus32.H_out;
        ack(0);
        start(0, dig1, M_Q2);
        wait_done(0, lat);
        chk("lat_q2", lat, 65);
        chk("dig_q", bus32.H_out, D_Q);
        ack(0);

        // Consumer stalls 20 cycles in DONE while producer pokes input_valid
        start(0, H256, M_ABC32);
        wait_done(0, lat);
        chk("lat_stall", lat, 65);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus32.input_valid = i[0];
            bus32.M_in = {16{32'hdeadbeef}};
            @(posedge clk);
            #1;
            chk("stall_ov", bus32.output_valid, 1);
            chk("stall_ir", bus32.input_ready, 0);
            chk("stall_dig", bus32.H_out, D_ABC32);
        end
        bus32.input_valid = 1'b0;
        ack(0);

        // output_ready high through ROUND must not shorten the block
        start(0, H256, M_ABC32);
        bus32.output_ready = 1'b1;
        wait_done(0, lat);
        chk("lat_early_ordy", lat, 65);
        chk("dig_early_ordy", bus32.H_out, D_ABC32);
        @(posedge clk);
        #1;
        chk("ov_early_ordy", bus32.output_valid, 0);
        chk("ir_early_ordy", bus32.input_ready, 1);
        bus32.output_ready = 1'b0;

        // Reset at round 30, with input_valid and output_ready also high
        start(0, H256, M_ABC32);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus32.input_valid = 1'b1;
        bus32.output_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ir", bus32.input_ready, 1);
        chk("midrst_ov", bus32.output_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus32.input_valid = 1'b0;
        bus32.output_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_idle", bus32.input_ready, 1);
        start(0, H256, M_ABC32);
        wait_done(0, lat);
        chk("lat_postrst", lat, 65);
        chk("dig_postrst", bus32.H_out, D_ABC32);
        ack(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
